atto_cfg_loader: RTL and testbench
==================================

# atto_cfg_loader

Parametrised configuration loader for the atto FPGA fabric. It streams bytes from the chip pins into the fabric's serial configuration chain, checks them with a trailing CRC-8, and can read the chain back non-destructively. It sits between the top-level pin mux and the fabric, and generalises the original fixed-length, load-only bit-banged chain to any chain length with load and readback modes and error detection.

## Interface
Parameters:
- CHAIN_LEN, 64: config chain length in bits, 8..1024; NBYTES = ceil(CHAIN_LEN/8)
- CRC_POLY, 8'h07: CRC-8 polynomial (init 0x00, MSB-first, no reflection, no final XOR)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- ena  in  1  design enable; low freezes all state, forces cfg_shift=0 and byte_out_valid=0
- start  in  1  begin operation in IDLE; ignored otherwise
- mode  in  1  sampled with start: 0=load, 1=readback
- byte_in  in  8  load data byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  loader accepts byte_in this cycle
- cfg_shift  out  1  fabric chain shift enable
- cfg_data  out  1  bit into chain head
- cfg_tail  in  1  bit out of chain tail
- byte_out  out  8  readback byte
- byte_out_valid  out  1  one-cycle strobe, byte_out valid
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of operation
- crc_err  out  1  sticky CRC mismatch flag, cleared by next accepted start

## Operation
- States: IDLE, LD_WAIT, LD_SHIFT, CRC_WAIT, RB_SHIFT, RB_EMIT, FINISH.
- IDLE --start&mode=0--> LD_WAIT; IDLE --start&mode=1--> RB_SHIFT; crc register cleared, crc_err cleared, bit/byte counters cleared.
- LD_WAIT: byte_ready=1; byte_valid&byte_ready latches byte, updates CRC over all 8 bits, -> LD_SHIFT.
- LD_SHIFT: cfg_shift=1, cfg_data = latched byte bit i (LSB first), one bit per cycle; 8 bits per byte except the last byte, which shifts only CHAIN_LEN-8*(NBYTES-1) low bits (upper bits still enter the CRC). After byte NBYTES-1 -> CRC_WAIT, else -> LD_WAIT.
- CRC_WAIT: byte_ready=1; accepted byte compared to CRC register; mismatch sets crc_err; -> FINISH. No chain shift.
- RB_SHIFT: cfg_shift=1, cfg_data=cfg_tail (chain rotates, contents preserved after CHAIN_LEN shifts); cfg_tail bits packed LSB first. After 8 bits, or after the final bit (partial byte zero-padded in upper bits) -> RB_EMIT.
- RB_EMIT: byte_out_valid=1 for one cycle, byte folded into CRC; if more bits remain -> RB_SHIFT; after last data byte emits one more byte = CRC, then -> FINISH.
- FINISH: done=1 one cycle, -> IDLE.
- Readback has no backpressure; consumer must take every strobe.
- Only CHAIN_LEN shifts occur per operation, exactly.

## Timing
- Reset values: byte_ready 0, cfg_shift 0, cfg_data 0, byte_out 0x00, byte_out_valid 0, busy 0, done 0, crc_err 0; state IDLE.
- Load, full byte: accept at cycle k, shifts at k+1..k+8, byte_ready high again k+9. Total after start with byte_valid held high: NBYTES*9 + CHAIN_LEN-8*NBYTES adjustment for partial last byte, +1 CRC accept, +1 FINISH.
- Readback: first cfg_shift cycle is the cycle after start; byte_out_valid one cycle after the 8th bit's shift cycle.
- Outputs are registered; byte_ready and cfg_shift are registered state decodes.
- ena=0 mid-operation: counters, CRC, state hold; resuming continues with no lost or duplicated bit.
- rst_n asserted mid-operation: immediate return to reset values; fabric chain contents undefined.
- start while busy, byte_valid in IDLE/shift states: ignored, no effect.

## Test plan
- CHAIN_LEN=72, load bytes 0x31..0x39 then CRC 0xF4 -> 72 cfg_shift cycles, cfg_data serial stream = bytes LSB-first, crc_err=0, done pulse once.
- Same load with CRC byte 0xF5 -> chain still loaded, crc_err=1 and held until next start.
- CHAIN_LEN=12, load 0xA5, 0x0F, CRC of {0xA5,0x0F} -> exactly 12 shifts, last byte shifts bits 1,1,1,1 only.
- Load 72-bit pattern, then readback -> byte_out strobes 0x31..0x39 then 0xF4, chain model unchanged after 72 rotations.
- Drop ena for 5 cycles mid LD_SHIFT and with byte_valid toggling randomly -> identical final chain and shift count to uninterrupted run.
- Assert rst_n low during RB_SHIFT -> all outputs reset same cycle; new start after release runs normally.

Source files
------------

// File: rtl/atto_cfg_loader.sv
// atto_cfg_loader
// Streams configuration bytes from the pins into the fabric's serial config chain
// (LSB first), checks them against a trailing CRC-8, and can rotate the chain back
// out non-destructively as a byte stream followed by its CRC.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ena             enable; low freezes all state and masks the strobes
//   start, mode     begin an operation in IDLE (mode 0 = load, 1 = readback)
//   byte_in/valid   load data in, byte_ready accepts it
//   cfg_shift/data  chain shift enable and head bit; cfg_tail is the chain tail bit
//   byte_out/valid  readback bytes (one-cycle strobe, no backpressure)
//   busy, done      operation in progress, end-of-operation pulse
//   crc_err         sticky CRC mismatch, cleared by the next accepted start
module atto_cfg_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter logic [7:0]  CRC_POLY  = 8'h07
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       cfg_shift,
  output logic       cfg_data,
  input  logic       cfg_tail,
  output logic [7:0] byte_out,
  output logic       byte_out_valid,
  output logic       busy,
  output logic       done,
  output logic       crc_err
);

  localparam int unsigned NBytes   = (CHAIN_LEN + 7) / 8;
  localparam int unsigned LastBits = CHAIN_LEN - 8 * (NBytes - 1);
  localparam int unsigned ByteW    = $clog2(NBytes + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLdWait,
    StLdShift,
    StCrcWait,
    StRbShift,
    StRbEmit,
    StFinish
  } state_e;

  // CRC-8, MSB first, no reflection, no final XOR
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  state_e           state_q;
  logic [2:0]       bit_cnt_q;
  logic [ByteW-1:0] byte_cnt_q;
  logic [7:0]       data_q;
  logic [7:0]       crc_q;
  logic             crc_phase_q;
  logic             rb_loop_q;
  logic             byte_ready_q;
  logic             cfg_shift_q;
  logic             cfg_data_q;
  logic [7:0]       byte_out_q;
  logic             byte_out_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             crc_err_q;

  logic       last_byte;
  logic [2:0] last_bit_idx;
  logic       last_bit;
  logic [7:0] rb_byte;

  assign last_byte    = (byte_cnt_q == ByteW'(NBytes - 1));
  // The final byte only carries the leftover chain bits
  assign last_bit_idx = last_byte ? 3'(LastBits - 1) : 3'd7;
  assign last_bit     = (bit_cnt_q == last_bit_idx);
  // Readback byte including the bit currently presented at the tail
  assign rb_byte      = data_q | ({7'd0, cfg_tail} << bit_cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      bit_cnt_q        <= '0;
      byte_cnt_q       <= '0;
      data_q           <= '0;
      crc_q            <= '0;
      crc_phase_q      <= 1'b0;
      rb_loop_q        <= 1'b0;
      byte_ready_q     <= 1'b0;
      cfg_shift_q      <= 1'b0;
      cfg_data_q       <= 1'b0;
      byte_out_q       <= '0;
      byte_out_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      crc_err_q        <= 1'b0;
    end else if (ena) begin
      done_q           <= 1'b0;
      byte_out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            crc_q       <= '0;
            crc_err_q   <= 1'b0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            data_q      <= '0;
            crc_phase_q <= 1'b0;
            busy_q      <= 1'b1;
            if (mode) begin
              state_q     <= StRbShift;
              cfg_shift_q <= 1'b1;
              rb_loop_q   <= 1'b1;
            end else begin
              state_q      <= StLdWait;
              byte_ready_q <= 1'b1;
            end
          end
        end
        StLdWait: begin
          if (byte_valid) begin
            data_q       <= byte_in;
            crc_q        <= crc8_next(crc_q, byte_in);
            byte_ready_q <= 1'b0;
            cfg_shift_q  <= 1'b1;
            cfg_data_q   <= byte_in[0];
            bit_cnt_q    <= '0;
            state_q      <= StLdShift;
          end
        end
        StLdShift: begin
          if (last_bit) begin
            cfg_shift_q  <= 1'b0;
            cfg_data_q   <= 1'b0;
            bit_cnt_q    <= '0;
            byte_ready_q <= 1'b1;
            if (last_byte) begin
              state_q <= StCrcWait;
            end else begin
              byte_cnt_q <= byte_cnt_q + ByteW'(1);
              state_q    <= StLdWait;
            end
          end else begin
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            cfg_data_q <= data_q[bit_cnt_q + 3'd1];
          end
        end
        StCrcWait: begin
          if (byte_valid) begin
            byte_ready_q <= 1'b0;
            if (byte_in != crc_q) crc_err_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StFinish;
          end
        end
        StRbShift: begin
          if (last_bit) begin
            cfg_shift_q      <= 1'b0;
            byte_out_q       <= rb_byte;
            byte_out_valid_q <= 1'b1;
            crc_q            <= crc8_next(crc_q, rb_byte);
            data_q           <= '0;
            bit_cnt_q        <= '0;
            state_q          <= StRbEmit;
          end else begin
            data_q    <= rb_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        StRbEmit: begin
          if (crc_phase_q) begin
            rb_loop_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StFinish;
          end else if (last_byte) begin
            // Trailing CRC byte; crc_q already covers the last data byte
            byte_out_q       <= crc_q;
            byte_out_valid_q <= 1'b1;
            crc_phase_q      <= 1'b1;
          end else begin
            byte_cnt_q  <= byte_cnt_q + ByteW'(1);
            cfg_shift_q <= 1'b1;
            state_q     <= StRbShift;
          end
        end
        StFinish: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes are masked while disabled so a frozen state never repeats a shift or pulse
  assign byte_ready     = byte_ready_q & ena;
  assign cfg_shift      = cfg_shift_q & ena;
  // Readback rotates the chain: tail bit feeds straight back into the head
  assign cfg_data       = rb_loop_q ? cfg_tail : cfg_data_q;
  assign byte_out       = byte_out_q;
  assign byte_out_valid = byte_out_valid_q & ena;
  assign busy           = busy_q;
  assign done           = done_q & ena;
  assign crc_err        = crc_err_q;

endmodule

// File: tb/tb_atto_cfg_loader.sv
// Testbench for atto_cfg_loader: a 72-bit instance driven from a vector table
// (fixed and randomized rows, random byte_valid and ena stalls) and a 12-bit
// instance for the partial-last-byte case. A behavioural chain model and a
// bit-serial CRC reference produce every expected value.
module tb_atto_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena;
  logic       start, mode, byte_valid, byte_ready, cfg_shift, cfg_data, cfg_tail;
  logic [7:0] byte_in, byte_out;
  logic       byte_out_valid, busy, done, crc_err;

  logic       start_s, mode_s, byte_valid_s, byte_ready_s, cfg_shift_s, cfg_data_s, cfg_tail_s;
  logic [7:0] byte_in_s, byte_out_s;
  logic       byte_out_valid_s, busy_s, done_s, crc_err_s;

  atto_cfg_loader #(.CHAIN_LEN(72), .CRC_POLY(8'h07)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .cfg_shift(cfg_shift), .cfg_data(cfg_data), .cfg_tail(cfg_tail),
    .byte_out(byte_out), .byte_out_valid(byte_out_valid), .busy(busy),
    .done(done), .crc_err(crc_err)
  );

  atto_cfg_loader #(.CHAIN_LEN(12), .CRC_POLY(8'h07)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_s), .mode(mode_s),
    .byte_in(byte_in_s), .byte_valid(byte_valid_s), .byte_ready(byte_ready_s),
    .cfg_shift(cfg_shift_s), .cfg_data(cfg_data_s), .cfg_tail(cfg_tail_s),
    .byte_out(byte_out_s), .byte_out_valid(byte_out_valid_s), .busy(busy_s),
    .done(done_s), .crc_err(crc_err_s)
  );

  // Fabric chain models: bit 0 is the head, the top bit is the tail
  logic [71:0] chain72 = '0;
  logic [11:0] chain12 = '0;
  bit          bits_q[$];
  bit          bits12_q[$];
  logic [7:0]  rb_q[$];
  logic [7:0]  rb12_q[$];
  int          done_cnt = 0;
  int          done12_cnt = 0;

  assign cfg_tail   = chain72[71];
  assign cfg_tail_s = chain12[11];

  always @(posedge clk) begin
    if (cfg_shift) begin
      chain72 <= {chain72[70:0], cfg_data};
      bits_q.push_back(cfg_data);
    end
    if (byte_out_valid) rb_q.push_back(byte_out);
    if (done) done_cnt <= done_cnt + 1;
    if (cfg_shift_s) begin
      chain12 <= {chain12[10:0], cfg_data_s};
      bits12_q.push_back(cfg_data_s);
    end
    if (byte_out_valid_s) rb12_q.push_back(byte_out_s);
    if (done_s) done12_cnt <= done12_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC-8 (poly 0x07): long division one message bit at a time
  function automatic logic [7:0] ref_crc(input logic [71:0] pat, input int nbytes);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int j = 0; j < nbytes; j++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ pat[8*j+i];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  typedef struct {
    logic [71:0] pat;
    logic [7:0]  crcb;
    logic        exp_err;
    logic [7:0]  exp_rbcrc;
    bit          rnd;
  } vec_t;

  vec_t tbl[8];

  task automatic load72(input logic [71:0] pat, input logic [7:0] crcb, input bit rnd,
                        output int lat);
    int idx, stall_left, stall_at, base;
    bit acc, stalled, got;
    idx = 0; acc = 0; stall_left = 0; stalled = 0; got = 0; lat = 0;
    stall_at = $urandom_range(1, 70);
    base = bits_q.size();
    @(negedge clk);
    start = 1'b1; mode = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (acc) idx++;
      if (done) begin got = 1; lat = cyc; break; end
      if (rnd && !stalled && cfg_shift && (bits_q.size() - base) >= stall_at) begin
        stalled = 1; stall_left = 5;
      end
      ena = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      byte_valid = (idx <= 9) && (!rnd || ($urandom_range(0, 1) == 1));
      if (!byte_valid) byte_in = 8'($urandom);
      else byte_in = (idx < 9) ? pat[8*idx +: 8] : crcb;
      #1;
      if (stalled && stall_left == 4) check("stall_no_shift", cfg_shift, 0);
      acc = byte_ready && byte_valid;
    end
    byte_valid = 1'b0;
    ena = 1'b1;
    check("load_done", got, 1);
  endtask

  task automatic rb72(output int lat, output int first_valid);
    bit got;
    got = 0; lat = 0; first_valid = 0;
    @(negedge clk);
    start = 1'b1; mode = 1'b1;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) begin
        check("rb_first_shift", cfg_shift, 1);
        check("rb_err_cleared", crc_err, 0);
      end
      if (byte_out_valid && first_valid == 0) first_valid = cyc;
      if (done) begin got = 1; lat = cyc; break; end
    end
    check("rb_done", got, 1);
  endtask

  task automatic run_row(input vec_t v);
    int lat, fv, b_bits, b_rb, b_done;
    logic [71:0] s, rev, rbd;
    for (int k = 0; k < 72; k++) rev[71-k] = v.pat[k];
    b_bits = bits_q.size(); b_done = done_cnt;
    load72(v.pat, v.crcb, v.rnd, lat);
    repeat (2) @(negedge clk);
    check("load_shifts", bits_q.size() - b_bits, 72);
    for (int k = 0; k < 72; k++) s[k] = bits_q[b_bits+k];
    check("load_stream", s, v.pat);
    check("load_chain", chain72, rev);
    check("load_crc_err", crc_err, v.exp_err);
    check("load_done_once", done_cnt - b_done, 1);
    if (!v.rnd) check("load_latency", lat, 83);
    b_bits = bits_q.size(); b_rb = rb_q.size(); b_done = done_cnt;
    rb72(lat, fv);
    repeat (2) @(negedge clk);
    check("rb_shifts", bits_q.size() - b_bits, 72);
    check("rb_count", rb_q.size() - b_rb, 10);
    for (int j = 0; j < 9; j++) rbd[8*j +: 8] = rb_q[b_rb+j];
    check("rb_data", rbd, v.pat);
    check("rb_crc", rb_q[b_rb+9], v.exp_rbcrc);
    check("rb_chain_kept", chain72, rev);
    check("rb_latency", lat, 83);
    check("rb_first_valid", fv, 9);
    check("rb_done_once", done_cnt - b_done, 1);
  endtask

  task automatic load12(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] crcb,
                        output int lat);
    int idx;
    bit acc, got;
    idx = 0; acc = 0; got = 0; lat = 0;
    @(negedge clk);
    start_s = 1'b1; mode_s = 1'b0;
    for (int cyc = 1; cyc < 500; cyc++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (acc) idx++;
      if (done_s) begin got = 1; lat = cyc; break; end
      byte_valid_s = (idx <= 2);
      byte_in_s = (idx == 0) ? b0 : (idx == 1) ? b1 : crcb;
      #1;
      acc = byte_ready_s && byte_valid_s;
    end
    byte_valid_s = 1'b0;
    check("load12_done", got, 1);
  endtask

  task automatic rb12(output int lat);
    bit got;
    got = 0; lat = 0;
    @(negedge clk);
    start_s = 1'b1; mode_s = 1'b1;
    for (int cyc = 1; cyc < 500; cyc++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (done_s) begin got = 1; lat = cyc; break; end
    end
    check("rb12_done", got, 1);
  endtask

  initial begin
    int          lat, bb, br;
    logic [7:0]  lb, crc_ld, crc_rb, c;
    logic [11:0] exp12, rev12, s12;
    logic [71:0] p;
    bit          bad;

    rst_n = 1'b0; ena = 1'b1;
    start = 1'b0; mode = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    start_s = 1'b0; mode_s = 1'b0; byte_valid_s = 1'b0; byte_in_s = 8'h00;

    tbl[0] = '{pat: 72'h39_38_37_36_35_34_33_32_31, crcb: 8'hF4, exp_err: 1'b0,
               exp_rbcrc: 8'hF4, rnd: 1'b0};
    tbl[1] = '{pat: 72'h39_38_37_36_35_34_33_32_31, crcb: 8'hF5, exp_err: 1'b1,
               exp_rbcrc: 8'hF4, rnd: 1'b0};
    tbl[2] = '{pat: 72'h0, crcb: 8'h00, exp_err: 1'b0, exp_rbcrc: 8'h00, rnd: 1'b0};
    tbl[3] = '{pat: 72'h0, crcb: 8'h01, exp_err: 1'b1, exp_rbcrc: 8'h00, rnd: 1'b1};
    for (int r = 4; r < 8; r++) begin
      p   = {8'($urandom), 32'($urandom), 32'($urandom)};
      c   = ref_crc(p, 9);
      bad = ($urandom_range(0, 2) == 0);
      tbl[r] = '{pat: p, crcb: bad ? (c ^ 8'($urandom_range(1, 255))) : c, exp_err: bad,
                 exp_rbcrc: c, rnd: 1'b1};
    end

    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", {byte_ready, cfg_shift, cfg_data, byte_out, byte_out_valid, busy,
                         done, crc_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 8; r++) run_row(tbl[r]);

    // Reset in the middle of a readback rotation
    @(negedge clk);
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("rst_pre_busy", busy, 1);
    check("rst_pre_shift", cfg_shift, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {byte_ready, cfg_shift, cfg_data, byte_out, byte_out_valid, busy,
                           done, crc_err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_row(tbl[0]);

    // 12-bit chain: last byte shifts only its low nibble, but all of it enters the CRC
    for (int t = 0; t < 2; t++) begin
      lb     = (t == 0) ? 8'h0F : 8'hFF;
      crc_ld = ref_crc({56'd0, lb, 8'hA5}, 2);
      crc_rb = ref_crc({56'd0, 8'h0F, 8'hA5}, 2);
      exp12  = {lb[3:0], 8'hA5};
      for (int k = 0; k < 12; k++) rev12[11-k] = exp12[k];
      bb = bits12_q.size();
      load12(8'hA5, lb, crc_ld, lat);
      repeat (2) @(negedge clk);
      check("load12_shifts", bits12_q.size() - bb, 12);
      for (int k = 0; k < 12; k++) s12[k] = bits12_q[bb+k];
      check("load12_stream", s12, exp12);
      check("load12_chain", chain12, rev12);
      check("load12_crc_err", crc_err_s, 0);
      check("load12_latency", lat, 16);
      bb = bits12_q.size(); br = rb12_q.size();
      rb12(lat);
      repeat (2) @(negedge clk);
      check("rb12_shifts", bits12_q.size() - bb, 12);
      check("rb12_count", rb12_q.size() - br, 3);
      check("rb12_bytes", {rb12_q[br+2], rb12_q[br+1], rb12_q[br]}, {crc_rb, 8'h0F, 8'hA5});
      check("rb12_chain_kept", chain12, rev12);
      check("rb12_latency", lat, 16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
